inst_mem_axi_rd: RTL

AXI4 read-only responder backed by an on-chip word-addressed memory, serving instruction fetch and cache-line refill read requests from the CPU core's AXI read masters. It accepts one AR request at a time, streams the burst on R with full RREADY back-pressure support, and flags illegal or out-of-range accesses with SLVERR. A simple load port fills the memory before or during execution.

---
 rtl/inst_mem_axi_rd.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/inst_mem_axi_rd.sv
// inst_mem_axi_rd: AXI4 read-only responder in front of an on-chip 32-bit
// word memory. It serves instruction fetch and line refill reads from the core.
// The block takes one AR request at a time. It streams ARLEN+1 beats on R with
// full RREADY back-pressure. Beats that are illegal or out of range return
// SLVERR with zero data. A load port writes the memory in any state.
//
// Optional feature: define AXI_RD_WRAP_EN to support WRAP bursts. Without it,
// a WRAP burst returns SLVERR on every beat.
//
// Ports
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   LD_EN/ADDR/DATA   memory load port (word index, read-first)
//   S_AXI_AR*         AR channel; LOCK/CACHE/PROT/QOS/USER are ignored
//   S_AXI_R*          R channel; RID echoes ARID, RUSER is tied to 0
module inst_mem_axi_rd #(
  parameter int unsigned C_S_AXI_THREAD_ID_WIDTH = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH      = 32,
  parameter int unsigned C_S_AXI_ARUSER_WIDTH    = 1,
  parameter int unsigned C_S_AXI_RUSER_WIDTH     = 4,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h2000_0000,
  parameter int unsigned C_MEM_WORDS             = 4096
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               LD_EN,
  input  logic [$clog2(C_MEM_WORDS)-1:0]     LD_ADDR,
  input  logic [31:0]                        LD_DATA,
  input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [7:0]                         S_AXI_ARLEN,
  input  logic [2:0]                         S_AXI_ARSIZE,
  input  logic [1:0]                         S_AXI_ARBURST,
  input  logic [1:0]                         S_AXI_ARLOCK,
  input  logic [3:0]                         S_AXI_ARCACHE,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic [3:0]                         S_AXI_ARQOS,
  input  logic [C_S_AXI_ARUSER_WIDTH-1:0]    S_AXI_ARUSER,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RLAST,
  output logic [C_S_AXI_RUSER_WIDTH-1:0]     S_AXI_RUSER,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY
);

  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IDW   = C_S_AXI_THREAD_ID_WIDTH;
  localparam int unsigned IDX_W = $clog2(C_MEM_WORDS);
  localparam int unsigned WORD_W = 32;

  // One past the last valid byte address. The extra bit keeps the compare
  // correct when the memory ends exactly at the top of the address space.
  localparam logic [AW:0] MEM_END = {1'b0, C_BASE_ADDR} + (AW+1)'(C_MEM_WORDS * 4);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic            arready_d, rvalid_d, rlast_d;
  logic [1:0]      rresp_d;
  logic [DW-1:0]   rdata_d;
  logic [IDW-1:0]  rid_d;

  logic [AW-1:0]   next_addr;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic            burst_err, range_err, rd_err;
  logic            load_beat;
  logic [7:0]      beat_cnt;

  logic [WORD_W-1:0] mem [C_MEM_WORDS];

  // Memory load port; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (LD_EN) begin
      mem[LD_ADDR] <= LD_DATA;
    end
  end

  // Address of the following beat, based on the captured burst type.
`ifdef AXI_RD_WRAP_EN
  logic [AW-1:0] wrap_mask;
  // The wrap window is (len+1)*4 bytes, so its byte mask is {len, 2'b11}.
  assign wrap_mask = AW'({len_q, 2'b11});
`endif

  always_comb begin
    next_addr = addr_q + AW'(4);
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = addr_q + AW'(4);
`ifdef AXI_RD_WRAP_EN
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + AW'(4)) & wrap_mask);
`endif
      default:     next_addr = addr_q + AW'(4);
    endcase
  end

  // FETCH reads the captured address. DATA pre-reads the beat that follows
  // the current handshake.
  assign rd_addr = (state == DATA) ? next_addr : addr_q;

`ifdef AXI_RD_WRAP_EN
  assign burst_err = (burst_q == 2'b11) ||
                     ((burst_q == BURST_WRAP) &&
                      !((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15)));
`else
  assign burst_err = (burst_q == 2'b11) || (burst_q == BURST_WRAP);
`endif

  assign range_err = (rd_addr < C_BASE_ADDR) || ({1'b0, rd_addr} >= MEM_END);
  assign rd_err    = (size_q != SIZE_WORD) || burst_err || range_err || (rd_addr[1:0] != 2'b00);
  assign rd_off    = rd_addr - C_BASE_ADDR;
  assign rd_idx    = IDX_W'(rd_off >> 2);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    arready_d = S_AXI_ARREADY;
    rvalid_d  = S_AXI_RVALID;
    rlast_d   = S_AXI_RLAST;
    rresp_d   = S_AXI_RRESP;
    rdata_d   = S_AXI_RDATA;
    rid_d     = S_AXI_RID;
    load_beat = 1'b0;
    beat_cnt  = cnt_q;

    case (state)
      IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          addr_d    = S_AXI_ARADDR;
          cnt_d     = S_AXI_ARLEN;
          len_d     = S_AXI_ARLEN;
          size_d    = S_AXI_ARSIZE;
          burst_d   = S_AXI_ARBURST;
          rid_d     = S_AXI_ARID;
          arready_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        load_beat = 1'b1;
        state_d   = DATA;
      end
      DATA: begin
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          if (cnt_q == 8'd0) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d    = next_addr;
            cnt_d     = cnt_q - 8'd1;
            beat_cnt  = cnt_q - 8'd1;
            load_beat = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Present a new beat. Without a load, every R output holds its value.
    if (load_beat) begin
      rvalid_d = 1'b1;
      rlast_d  = (beat_cnt == 8'd0);
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_err ? '0 : DW'(mem[rd_idx]);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      S_AXI_RID     <= '0;
    end else begin
      state         <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      S_AXI_ARREADY <= arready_d;
      S_AXI_RVALID  <= rvalid_d;
      S_AXI_RLAST   <= rlast_d;
      S_AXI_RRESP   <= rresp_d;
      S_AXI_RDATA   <= rdata_d;
      S_AXI_RID     <= rid_d;
    end
  end

  assign S_AXI_RUSER = '0;

  // AR sideband fields carry no meaning for this memory.
  logic unused_ok;
`ifdef AXI_RD_WRAP_EN
  assign unused_ok = ^{S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER};
`else
  assign unused_ok = ^{S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER, len_q};
`endif

endmodule
